// File: rtl/left_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : left_shift_seq
//  Description : Multi-cycle logical left shifter for the ALU shift path.
//                Shifts by up to STEP bits per cycle with zero fill, reports
//                completion with a one-cycle data_ready pulse and keeps a
//                sticky overflow flag for any 1 bit pushed out of the MSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module left_shift_seq #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5,
    parameter int STEP  = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] data_out,
    output logic             data_ready,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // STEP may be larger than the largest representable amount; saturating it
    // keeps the per-cycle step in AMT_W bits without changing behaviour, since
    // the step is always clamped to the remaining amount anyway.
    localparam int               C_AMT_MAX  = (1 << AMT_W) - 1;
    localparam int               C_STEP_SAT = (STEP > C_AMT_MAX) ? C_AMT_MAX : STEP;
    localparam logic [AMT_W-1:0] C_STEP     = AMT_W'(C_STEP_SAT);

    state_t           r_state;
    logic [WIDTH-1:0] r_data_out;
    logic [AMT_W-1:0] r_remaining;
    logic             r_overflow;
    logic             r_data_ready;
    logic             r_busy;

    logic [AMT_W-1:0] w_step;
    logic [AMT_W-1:0] w_rem_next;
    logic [WIDTH-1:0] w_shifted;
    logic             w_lost;

    // Per-cycle shift: clamp step to what is left, shift, and detect lost ones.
    always_comb begin
        w_step     = (r_remaining > C_STEP) ? C_STEP : r_remaining;
        w_shifted  = r_data_out << w_step;
        w_rem_next = r_remaining - w_step;
        w_lost     = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(w_step)) begin
                w_lost = w_lost | r_data_out[WIDTH-1-i];
            end
        end
    end

    // Control FSM with registered result, flag and status outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_data_out   <= '0;
            r_remaining  <= '0;
            r_overflow   <= 1'b0;
            r_data_ready <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (ctrl_start) begin
                        r_data_out  <= data_in;
                        r_remaining <= amt;
                        r_overflow  <= 1'b0;
                        if (amt == '0) begin
                            r_state      <= S_DONE;
                            r_data_ready <= 1'b1;
                            r_busy       <= 1'b0;
                        end else begin
                            r_state      <= S_SHIFT;
                            r_data_ready <= 1'b0;
                            r_busy       <= 1'b1;
                        end
                    end else begin
                        r_state      <= S_IDLE;
                        r_data_ready <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_data_out  <= w_shifted;
                    r_remaining <= w_rem_next;
                    r_overflow  <= r_overflow | w_lost;
                    if (w_rem_next == '0) begin
                        r_state      <= S_DONE;
                        r_data_ready <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_state      <= S_SHIFT;
                        r_data_ready <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_data_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_ready = r_data_ready;
    assign overflow   = r_overflow;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_left_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_left_shift_seq
//  Description : Self-checking bench for left_shift_seq. Expected results are
//                queued when an operation is started and compared whenever
//                the DUT raises data_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_left_shift_seq;

    localparam int WIDTH = 32;
    localparam int AMT_W = 5;
    localparam int STEP  = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             ctrl_start;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] data_out;
    logic             data_ready;
    logic             overflow;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {overflow, data}
    logic [WIDTH:0] sb_q[$];

    left_shift_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W), .STEP(STEP)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ctrl_start (ctrl_start),
        .data_in    (data_in),
        .amt        (amt),
        .data_out   (data_out),
        .data_ready (data_ready),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] d, input int a);
        logic [WIDTH-1:0] r;
        logic             o;
        r = d << a;
        o = (a == 0) ? 1'b0 : |(d >> (WIDTH - a));
        return {o, r};
    endfunction

    // Scoreboard consumer: every result pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (data_ready === 1'b1) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected_ready: observed ready with empty queue, expected no ready");
            end
            if (sb_q.size() > 0) begin
                logic [WIDTH:0] exp_v;
                exp_v = sb_q.pop_front();
                checks++;
                assert ({overflow, data_out} === exp_v) else begin
                    errors++;
                    $error("FAIL sb_result: observed ovf=%0b data=%h, expected ovf=%0b data=%h",
                           overflow, data_out, exp_v[WIDTH], exp_v[WIDTH-1:0]);
                end
            end
        end
    end

    // Called at a negedge. Starts an operation, optionally pulses a start with
    // amt=1 during busy cycle intr, and checks the busy count and ready pulse.
    // With chain set it returns on the ready cycle so a new start can follow.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input int a,
                          input int intr, input bit chain);
        int  cnt;
        bit  seen;
        int  k;
        logic [WIDTH:0] exp_v;
        exp_v = model(d, a);
        k     = (a + STEP - 1) / STEP;
        sb_q.push_back(exp_v);
        ctrl_start = 1'b1;
        data_in    = d;
        amt        = AMT_W'(a);
        cnt  = 0;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clock);
            if (busy === 1'b1) cnt++;
            if (data_ready === 1'b1) seen = 1'b1;
            if (intr != 0 && cnt == intr && busy === 1'b1) begin
                ctrl_start = 1'b1;
                amt        = AMT_W'(1);
                data_in    = $urandom;
            end else begin
                ctrl_start = 1'b0;
            end
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL %s_timeout: observed no ready in 40 cycles, expected ready", tag);
        end
        checks++;
        assert (cnt == k) else begin
            errors++;
            $error("FAIL %s_busy_cycles: observed %0d, expected %0d", tag, cnt, k);
        end
        if (!chain) begin
            @(negedge clock);
            checks++;
            assert (data_ready === 1'b0 && busy === 1'b0) else begin
                errors++;
                $error("FAIL %s_pulse: observed ready=%0b busy=%0b, expected 0 0", tag, data_ready, busy);
            end
            checks++;
            assert ({overflow, data_out} === exp_v) else begin
                errors++;
                $error("FAIL %s_hold: observed ovf=%0b data=%h, expected ovf=%0b data=%h",
                       tag, overflow, data_out, exp_v[WIDTH], exp_v[WIDTH-1:0]);
            end
        end
    endtask

    initial begin
        int cnt;
        reset_n    = 1'b0;
        ctrl_start = 1'b0;
        data_in    = '0;
        amt        = '0;
        repeat (3) @(negedge clock);
        checks++;
        assert (data_out === '0 && data_ready === 1'b0 && overflow === 1'b0 && busy === 1'b0) else begin
            errors++;
            $error("FAIL reset_state: observed data=%h ready=%0b ovf=%0b busy=%0b, expected all 0",
                   data_out, data_ready, overflow, busy);
        end
        reset_n = 1'b1;
        @(negedge clock);

        run_op("t1_amt1",    32'h2AAAAAAA, 1,  0, 1'b0);
        run_op("t2_amt4",    32'hF0000001, 4,  0, 1'b0);
        run_op("t3_amt31",   32'h00000001, 31, 0, 1'b0);
        run_op("t4_amt0",    32'hDEADBEEF, 0,  0, 1'b0);
        run_op("t5_ignore",  32'h12345678, 20, 2, 1'b0);

        // Back-to-back: second start lands in the DONE cycle of the first.
        run_op("b2b_a",      32'h8000000F, 5,  0, 1'b1);
        run_op("b2b_b",      32'h0F0F0F0F, 8,  0, 1'b1);
        run_op("b2b_c",      32'hFFFFFFFF, 0,  0, 1'b0);

        // Step boundaries and a few random operands.
        run_op("step_exact", 32'hC0000003, 8,  0, 1'b0);
        run_op("step_rem",   32'h40000000, 9,  0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op("rand", $urandom, int'($urandom_range(0, 31)), 0, 1'b0);
        end

        // Abort in the third SHIFT cycle: nothing queued, so any later ready is flagged.
        ctrl_start = 1'b1;
        data_in    = 32'h00000001;
        amt        = AMT_W'(31);
        cnt        = 0;
        for (int t = 0; t < 20 && cnt < 3; t++) begin
            @(negedge clock);
            ctrl_start = 1'b0;
            if (busy === 1'b1) cnt++;
        end
        checks++;
        assert (cnt == 3) else begin
            errors++;
            $error("FAIL t6_reach_shift3: observed %0d busy cycles, expected 3", cnt);
        end
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        assert (data_out === '0 && data_ready === 1'b0 && overflow === 1'b0 && busy === 1'b0) else begin
            errors++;
            $error("FAIL t6_abort: observed data=%h ready=%0b ovf=%0b busy=%0b, expected all 0",
                   data_out, data_ready, overflow, busy);
        end
        reset_n = 1'b1;
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clock);
            if (data_ready === 1'b1 || busy === 1'b1) cnt++;
        end
        checks++;
        assert (cnt == 0) else begin
            errors++;
            $error("FAIL t6_idle_after_abort: observed %0d active cycles, expected 0", cnt);
        end
        run_op("t6_restart", 32'h00000003, 30, 0, 1'b0);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d pending, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
